// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main control unit.
// Moore FSM sequencing fetch, decode, execute, memory and writeback steps.
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       alu_zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] B_RT   = 2'b00;
    localparam logic [1:0] B_FOUR = 2'b01;
    localparam logic [1:0] B_IMM  = 2'b10;
    localparam logic [1:0] B_IMM2 = 2'b11;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t state_q;
    state_t state_d;

    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_j;
    logic is_addi;
    logic is_mem;
    logic is_branch;

    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;

    // Opcode classification; classes are mutually exclusive.
    always_comb begin
        is_rtype  = (opcode_i == OP_RTYPE);
        is_lw     = (opcode_i == OP_LW);
        is_sw     = (opcode_i == OP_SW);
        is_beq    = (opcode_i == OP_BEQ);
        is_bne    = (opcode_i == OP_BNE);
        is_j      = (opcode_i == OP_J);
        is_addi   = (opcode_i == OP_ADDI);
        is_mem    = is_lw | is_sw;
        is_branch = is_beq | is_bne;
    end

    // State register; reset wins even in the middle of a memory wait.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and raw control decode from the current state.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = B_RT;
        alu_op     = OP_ADD;
        pc_source  = PC_ALU;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = B_FOUR;
                ir_write  = mem_ready_i;
                pc_write  = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = B_IMM2;
                unique case (1'b1)
                    is_mem:    state_d = S_MEM_ADDR;
                    is_rtype:  state_d = S_EXECUTE;
                    is_branch: state_d = S_BRANCH;
                    is_j:      state_d = S_JUMP;
                    is_addi:   state_d = S_ADDI_EXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
                if (is_sw) begin
                    state_d = S_MEM_WRITE;
                end else if (is_lw) begin
                    state_d = S_MEM_READ;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = B_RT;
                alu_op    = OP_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = B_RT;
                alu_op    = OP_SUB;
                pc_source = PC_ALUOUT;
                pc_write  = (is_beq & alu_zero_i) |
                            (is_bne & ~alu_zero_i);
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = PC_JUMP;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Everything is forced quiet while reset is held low.
    always_comb begin
        pc_write_o   = rst_i & pc_write;
        iord_o       = rst_i & iord;
        mem_read_o   = rst_i & mem_read;
        mem_write_o  = rst_i & mem_write;
        ir_write_o   = rst_i & ir_write;
        reg_dst_o    = rst_i & reg_dst;
        mem_to_reg_o = rst_i & mem_to_reg;
        reg_write_o  = rst_i & reg_write;
        alu_src_a_o  = rst_i & alu_src_a;
        alu_src_b_o  = rst_i ? alu_src_b : 2'b00;
        alu_op_o     = rst_i ? alu_op : 2'b00;
        pc_source_o  = rst_i ? pc_source : 2'b00;
        state_o      = rst_i ? state_q : 4'd0;
        illegal_o    = rst_i & illegal;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: latency table, corner sequences,
// and random instruction streams against an instruction-level model.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] opcode_i;
    logic       alu_zero_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       iord_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] alu_op_o;
    logic [1:0] pc_source_o;
    logic [3:0] state_o;
    logic       illegal_o;

    int checks = 0;
    int failures = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    multicycle_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .opcode_i     (opcode_i),
        .alu_zero_i   (alu_zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .iord_o       (iord_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .pc_source_o  (pc_source_o),
        .state_o      (state_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    wire [15:0] dut_vec = {pc_write_o, iord_o, mem_read_o, mem_write_o,
                           ir_write_o, reg_dst_o, mem_to_reg_o,
                           reg_write_o, alu_src_a_o, alu_src_b_o,
                           alu_op_o, pc_source_o, illegal_o};

    typedef struct {
        logic [5:0] op;
        bit         z;
        int         cycles;
        int         regw;
        int         pcw;
        int         memw;
        int         ill;
    } vec_t;

    vec_t tbl[10];
    int   path_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_BNE || op == OP_J ||
               op == OP_ADDI;
    endfunction

    // Expected control word for a given state code, straight from the
    // per-state output table.
    function automatic logic [15:0] exp_vec(input int st, input bit rdy,
                                            input bit z,
                                            input logic [5:0] op);
        logic       pw  = 0, io  = 0, mr = 0, mw = 0, irw = 0;
        logic       rd  = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
        logic [1:0] sb  = 0, ao  = 0, ps = 0;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            1:  begin sb = 2'b11; ill = !legal(op); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin
                    sa = 1; ao = 2'b01; ps = 2'b01;
                    pw = (op == OP_BEQ) ? z : !z;
                end
            9:  begin ps = 2'b10; pw = 1; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pw, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, ill};
    endfunction

    // Sequence of state codes an instruction walks through.
    task automatic build_path(input logic [5:0] op);
        case (op)
            OP_LW:          path_q = {0, 1, 2, 3, 4};
            OP_SW:          path_q = {0, 1, 2, 5};
            OP_R:           path_q = {0, 1, 6, 7};
            OP_BEQ, OP_BNE: path_q = {0, 1, 8};
            OP_J:           path_q = {0, 1, 9};
            OP_ADDI:        path_q = {0, 1, 10, 11};
            default:        path_q = {0, 1};
        endcase
    endtask

    task automatic drive(input bit rdy, input bit z);
        mem_ready_i = rdy;
        alu_zero_i  = z;
        @(negedge clk_i);
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    logic [5:0] ops[7] = '{OP_R, OP_LW, OP_SW, OP_BEQ,
                           OP_BNE, OP_J, OP_ADDI};
    logic [5:0] bads[3] = '{OP_BAD, 6'b000001, 6'b110000};

    initial begin
        int cyc, rw, pw, mw, il, n;
        logic [5:0] op;
        bit rdy, z;

        tbl[0] = '{OP_LW,   1'b0, 5, 1, 0, 0, 0};
        tbl[1] = '{OP_SW,   1'b0, 4, 0, 0, 1, 0};
        tbl[2] = '{OP_R,    1'b0, 4, 1, 0, 0, 0};
        tbl[3] = '{OP_ADDI, 1'b0, 4, 1, 0, 0, 0};
        tbl[4] = '{OP_BEQ,  1'b1, 3, 0, 1, 0, 0};
        tbl[5] = '{OP_BEQ,  1'b0, 3, 0, 0, 0, 0};
        tbl[6] = '{OP_BNE,  1'b1, 3, 0, 0, 0, 0};
        tbl[7] = '{OP_BNE,  1'b0, 3, 0, 1, 0, 0};
        tbl[8] = '{OP_J,    1'b0, 3, 0, 1, 0, 0};
        tbl[9] = '{OP_BAD,  1'b0, 2, 0, 0, 0, 1};

        rst_i       = 1'b0;
        opcode_i    = OP_LW;
        mem_ready_i = 1'b1;
        alu_zero_i  = 1'b1;

        // Outputs held quiet while in reset, even with ready asserted.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1);
            check("rst_outputs", dut_vec, 16'h0);
            check("rst_state", state_o, 0);
            adv();
        end
        rst_i = 1'b1;

        // lw trace with no wait states.
        opcode_i = OP_LW;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            check("lw_state", state_o, i);
            check("lw_regw", reg_write_o, i == 4);
            check("lw_m2r", mem_to_reg_o, i == 4);
            adv();
        end
        check("lw_end", state_o, 0);

        // Fetch stall of two cycles.
        opcode_i = OP_J;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0);
            check("fwait_ir", ir_write_o, 0);
            check("fwait_pc", pc_write_o, 0);
            check("fwait_st", state_o, 0);
            adv();
        end
        drive(1'b1, 1'b0);
        check("fgo_ir", ir_write_o, 1);
        check("fgo_pc", pc_write_o, 1);
        adv();
        check("fgo_dec", state_o, 1);
        drive(1'b1, 1'b0);
        adv();
        drive(1'b1, 1'b0);
        check("j_pc", {pc_write_o, pc_source_o}, 3'b110);
        adv();
        check("j_end", state_o, 0);

        // sw with three wait cycles in MEM_WRITE.
        opcode_i = OP_SW;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            adv();
        end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 1'b0);
            if (mem_write_o) n++;
            check("sw_state", state_o, 5);
            adv();
        end
        check("sw_memw_cycles", n, 4);
        check("sw_end", state_o, 0);

        // Reset asserted while MEM_READ is waiting.
        opcode_i = OP_LW;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            adv();
        end
        drive(1'b0, 1'b0);
        check("mrwait_state", state_o, 3);
        adv();
        rst_i = 1'b0;
        drive(1'b0, 1'b0);
        check("mrrst_out", dut_vec, 16'h0);
        adv();
        check("mrrst_state", state_o, 0);
        drive(1'b1, 1'b0);
        check("mrrst_out2", dut_vec, 16'h0);
        adv();
        rst_i = 1'b1;
        drive(1'b1, 1'b0);
        check("post_rst_state", state_o, 0);
        check("post_rst_mr", mem_read_o, 1);
        adv();
        drive(1'b1, 1'b0);
        adv();
        drive(1'b1, 1'b0);
        adv();
        drive(1'b1, 1'b0);
        adv();
        drive(1'b1, 1'b0);
        adv();
        check("resync", state_o, 0);

        // Latency and side-effect table with no wait states.
        foreach (tbl[k]) begin
            opcode_i = tbl[k].op;
            cyc = 0; rw = 0; pw = 0; mw = 0; il = 0;
            for (int c = 0; c < 20; c++) begin
                drive(1'b1, tbl[k].z);
                if (state_o != 0) begin
                    pw += pc_write_o;
                    rw += reg_write_o;
                    mw += mem_write_o;
                end
                il += illegal_o;
                cyc++;
                adv();
                if (state_o == 0) break;
            end
            check($sformatf("tbl%0d_cycles", k), cyc, tbl[k].cycles);
            check($sformatf("tbl%0d_regw", k), rw, tbl[k].regw);
            check($sformatf("tbl%0d_pcw", k), pw, tbl[k].pcw);
            check($sformatf("tbl%0d_memw", k), mw, tbl[k].memw);
            check($sformatf("tbl%0d_ill", k), il, tbl[k].ill);
        end

        // Random instruction stream with random memory stalls.
        for (int t = 0; t < 150; t++) begin
            n = $urandom_range(0, 8);
            op = (n < 7) ? ops[n] : bads[$urandom_range(0, 2)];
            opcode_i = op;
            build_path(op);
            for (int idx = 0; idx < path_q.size(); ) begin
                rdy = ($urandom_range(0, 3) != 0);
                z   = $urandom_range(0, 1) == 1;
                drive(rdy, z);
                check("rnd_state", state_o, path_q[idx]);
                check("rnd_outs", dut_vec,
                      exp_vec(path_q[idx], rdy, z, op));
                check("rnd_mem_excl", mem_read_o & mem_write_o, 0);
                check("rnd_wr_excl", reg_write_o & pc_write_o, 0);
                if (!((path_q[idx] == 0 || path_q[idx] == 3 ||
                       path_q[idx] == 5) && !rdy))
                    idx++;
                adv();
            end
        end
        drive(1'b1, 1'b0);
        check("rnd_end", state_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL be a single-clock design with a synchronous, active-low reset; the clock is clk_i and the reset is rst_i.
REQ-002 Ports SHALL be as follows:
- clk_i, input, 1 bit: clock; all state updates occur on the rising edge.
- rst_i, input, 1 bit: synchronous active-low reset.
- opcode_i, input, 6 bits: instruction opcode from the instruction register; stable from DECODE onward.
- alu_zero_i, input, 1 bit: ALU zero flag.
- mem_ready_i, input, 1 bit: memory access complete this cycle.
- pc_write_o, output, 1 bit: PC load enable; folds in the branch condition.
- iord_o, output, 1 bit: memory address select (0 = PC, 1 = ALUOut).
- mem_read_o, output, 1 bit: memory read strobe.
- mem_write_o, output, 1 bit: memory write strobe.
- ir_write_o, output, 1 bit: instruction register load.
- reg_dst_o, output, 1 bit: write register select (0 = rt, 1 = rd).
- mem_to_reg_o, output, 1 bit: writeback select (0 = ALUOut, 1 = MDR).
- reg_write_o, output, 1 bit: register file write enable.
- alu_src_a_o, output, 1 bit: ALU A select (0 = PC, 1 = rs).
- alu_src_b_o, output, 2 bits: ALU B select (00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2).
- alu_op_o, output, 2 bits: ALU op (00 = add, 01 = sub, 10 = funct-decoded).
- pc_source_o, output, 2 bits: PC source (00 = ALU result, 01 = ALUOut, 10 = jump target).
- state_o, output, 4 bits: current state encoding, for debug.
- illegal_o, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-003 State encoding SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11; codes 12-15 SHALL transition to FETCH.
REQ-004 Supported opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000.
REQ-005 All outputs SHALL be decoded from the current state (Moore), except where REQ-014 makes pc_write_o depend on alu_zero_i; any output not listed for a state SHALL be 0.
REQ-006 FETCH SHALL drive: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=00, pc_source_o=00, ir_write_o=mem_ready_i, pc_write_o=mem_ready_i.
REQ-007 FETCH SHALL remain in FETCH while mem_ready_i=0 and go to DECODE when mem_ready_i=1.
REQ-008 DECODE SHALL drive alu_src_a_o=0, alu_src_b_o=11, alu_op_o=00, then transition by opcode:
- lw/sw -> MEM_ADDR
- R-type -> EXECUTE
- beq/bne -> BRANCH
- j -> JUMP
- addi -> ADDI_EXEC
- any other opcode -> FETCH, with illegal_o=1 during that DECODE cycle.
REQ-009 MEM_ADDR SHALL drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00, then go to MEM_READ on lw or MEM_WRITE on sw.
REQ-010 MEM_READ SHALL drive mem_read_o=1, iord_o=1, hold while mem_ready_i=0, and go to MEM_WB when mem_ready_i=1.
REQ-011 MEM_WB SHALL drive reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0, then go to FETCH.
REQ-012 MEM_WRITE SHALL drive mem_write_o=1, iord_o=1, hold while mem_ready_i=0, and go to FETCH when mem_ready_i=1.
REQ-013 EXECUTE SHALL drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=10, then go to ALU_WB; ALU_WB SHALL drive reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0, then go to FETCH.
REQ-014 BRANCH SHALL drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_source_o=01, with pc_write_o=alu_zero_i for beq and pc_write_o=~alu_zero_i for bne, then go to FETCH.
REQ-015 JUMP SHALL drive pc_source_o=10, pc_write_o=1, then go to FETCH.
REQ-016 ADDI_EXEC SHALL drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00, then go to ADDI_WB; ADDI_WB SHALL drive reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0, then go to FETCH.
REQ-017 mem_read_o and mem_write_o SHALL never be 1 in the same cycle; reg_write_o and pc_write_o SHALL never be 1 in the same cycle.
REQ-018 Instruction latency SHALL be, in cycles with zero memory wait:
- lw: 5
- sw, R-type, addi: 4
- beq, bne, j: 3
Each wait cycle with mem_ready_i=0 in FETCH, MEM_READ or MEM_WRITE SHALL add one cycle.

Reset
REQ-019 When rst_i=0 at a rising edge, the state SHALL become FETCH, regardless of the current state, including mid-wait in MEM_READ or MEM_WRITE.
REQ-020 While rst_i=0, all outputs SHALL be 0 and state_o SHALL be 0; mem_read_o SHALL assert only after rst_i returns to 1.

Verification
REQ-021 Reset, then lw (100011) with mem_ready_i=1 -> state_o 0,1,2,3,4,0; reg_write_o=1 and mem_to_reg_o=1 only in state 4.
REQ-022 beq with alu_zero_i=1 -> pc_write_o=1 in state 8 with pc_source_o=01; bne with alu_zero_i=1 -> pc_write_o=0 in state 8.
REQ-023 sw with mem_ready_i held at 0 for 3 cycles in MEM_WRITE -> mem_write_o=1 for 4 cycles, then state_o=0.
REQ-024 Opcode 111111 -> illegal_o=1 for exactly one cycle in DECODE, next state_o=0, and no register, memory or PC write occurs.
REQ-025 rst_i=0 during MEM_READ wait -> next cycle state_o=0 and all outputs 0.
REQ-026 FETCH with mem_ready_i=0 for 2 cycles -> ir_write_o=0 and pc_write_o=0 for those 2 cycles, then both 1 for one cycle.
